// File: rtl/ahb_ssram_bridge_ws.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ahb_ssram_bridge_ws: AHB-Lite slave to 1-cycle SSRAM, posted write buffer |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ahb_ssram_bridge_ws #(
  parameter int AW          = 12,
  parameter int DW          = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic                          HSEL,
  input  logic [1:0]                    HTRANS,
  input  logic                          HWRITE,
  input  logic [2:0]                    HSIZE,
  input  logic [AW-1:0]                 HADDR,
  input  logic                          HREADY,
  input  logic [DW-1:0]                 HWDATA,
  output logic [DW-1:0]                 HRDATA,
  output logic                          HREADYOUT,
  output logic                          HRESP,
  output logic                          ram_cs,
  output logic                          ram_we,
  output logic [DW/8-1:0]               ram_be,
  output logic [AW-$clog2(DW/8)-1:0]    ram_addr,
  output logic [DW-1:0]                 ram_wdata,
  input  logic [DW-1:0]                 ram_rdata
);

  localparam int NB    = DW / 8;
  localparam int LB    = $clog2(NB);
  localparam int WAW   = AW - LB;
  localparam int WS_M1 = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_ERR1    = 2'd2,
    ST_ERR2    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             wp_valid_q;
  logic [WAW-1:0]   wp_addr_q;
  logic [NB-1:0]    wp_be_q;
  logic             buf_valid_q, buf_valid_d;
  logic [WAW-1:0]   buf_addr_q, buf_addr_d;
  logic [NB-1:0]    buf_be_q, buf_be_d;
  logic [DW-1:0]    buf_data_q, buf_data_d;
  logic             rd_dp_q;
  logic [WAW-1:0]   rd_addr_q;
  logic [DW-1:0]    rdata_q;

  logic             w_accept, w_size_ok, w_rd_acc, w_wr_acc, w_err_acc, w_hit;
  logic [NB-1:0]    w_mask;
  logic [DW-1:0]    w_merged;
  logic             unused_htrans0;

  assign unused_htrans0 = HTRANS[0];

  assign w_accept  = HSEL & HREADY & HTRANS[1];
  assign w_size_ok = (HSIZE <= 3'(LB));
  assign w_rd_acc  = w_accept & ~HWRITE & w_size_ok;
  assign w_wr_acc  = w_accept &  HWRITE & w_size_ok;
  assign w_err_acc = w_accept & ~w_size_ok;

  // A lane belongs to the transfer when it shares the address bits above HSIZE.
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      w_mask[b] = ((LB'(b) ^ HADDR[LB-1:0]) >> HSIZE) == '0;
    end
  end

  assign w_hit = buf_valid_q && (buf_addr_q == rd_addr_q);

  always_comb begin
    for (int b = 0; b < NB; b++) begin
      w_merged[8*b +: 8] = (w_hit && buf_be_q[b]) ? buf_data_q[8*b +: 8]
                                                   : ram_rdata[8*b +: 8];
    end
  end

  assign HRDATA = rd_dp_q ? w_merged : rdata_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        HRESP = (state_q == ST_ERR2);
        if (w_err_acc) begin
          state_d = ST_ERR1;
        end else if (w_rd_acc && (WAIT_STATES > 0)) begin
          state_d = ST_RD_WAIT;
          cnt_d   = 2'(WS_M1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt_q == 2'd0) state_d = ST_IDLE;
        else               cnt_d   = cnt_q - 2'd1;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reads own the port in their address phase; the buffered write drains otherwise.
  always_comb begin
    ram_cs      = 1'b0;
    ram_we      = 1'b0;
    ram_be      = '0;
    ram_addr    = buf_addr_q;
    ram_wdata   = buf_data_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_be_d    = buf_be_q;
    buf_data_d  = buf_data_q;
    if (w_rd_acc) begin
      ram_cs   = 1'b1;
      ram_addr = HADDR[AW-1:LB];
    end else if (buf_valid_q) begin
      ram_cs      = 1'b1;
      ram_we      = 1'b1;
      ram_be      = buf_be_q;
      buf_valid_d = 1'b0;
    end
    if (wp_valid_q) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = wp_addr_q;
      buf_be_d    = wp_be_q;
      buf_data_d  = HWDATA;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      wp_valid_q  <= 1'b0;
      wp_addr_q   <= '0;
      wp_be_q     <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_be_q    <= '0;
      buf_data_q  <= '0;
      rd_dp_q     <= 1'b0;
      rd_addr_q   <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wp_valid_q  <= w_wr_acc;
      if (w_wr_acc) begin
        wp_addr_q <= HADDR[AW-1:LB];
        wp_be_q   <= w_mask;
      end
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_be_q    <= buf_be_d;
      buf_data_q  <= buf_data_d;
      rd_dp_q     <= w_rd_acc;
      if (w_rd_acc) rd_addr_q <= HADDR[AW-1:LB];
      if (rd_dp_q)  rdata_q   <= w_merged;
    end
  end

endmodule
`default_nettype wire

// File: doc/ahb_ssram_bridge_ws.md
# ahb_ssram_bridge_ws

AHB-Lite slave bridging a single-port synchronous SRAM, the parametrised successor of the 32-bit zero-wait AHB-to-SSRAM bridge. It adds configurable data width and read wait states, a one-entry posted-write buffer with read forwarding for back-to-back read/write pipelining, and ERROR responses for unsupported transfer sizes. It sits between the AHB interconnect (or the bench `ahb_driver`) and an SRAM macro with one-cycle read latency.

## Interface
- `AW`, 12: AHB byte-address width.
- `DW`, 32: data width, 32 or 64. `NB = DW/8` byte lanes, `LB = log2(NB)`.
- `WAIT_STATES`, 0: extra read data-phase cycles, 0..3.

- `HCLK`  in  1  clock; all logic on rising edge.
- `HRESET`  in  1  asynchronous, active-high reset.
- `HSEL`, `HTRANS[1:0]`, `HWRITE`, `HSIZE[2:0]`, `HADDR[AW-1:0]`, `HREADY`  in  AHB address-phase controls.
- `HWDATA`  in  DW  write data, valid in the data phase.
- `HRDATA`  out  DW  read data.
- `HREADYOUT`  out  1  transfer done / wait.
- `HRESP`  out  1  0 OKAY, 1 ERROR.
- `ram_cs`, `ram_we`  out  1  SRAM select and write enable.
- `ram_be`  out  NB  byte write enables.
- `ram_addr`  out  AW-LB  word address.
- `ram_wdata`  out  DW;  `ram_rdata`  in  DW, valid one cycle after a read strobe.

## Operation
- Accept: `HSEL & HREADY & HTRANS[1]`. IDLE/BUSY give a zero-wait OKAY with no access.
- Lanes: `HSIZE` ≤ LB valid; mask = `(1<<(1<<HSIZE))-1` shifted by `HADDR[LB-1:0]` aligned down to the size. `HSIZE` > LB → ERROR, no SRAM access.
- Writes are posted: address/mask latched in the address phase, `HWDATA` captured into the write buffer at the end of the zero-wait data phase; buffer valid from the next cycle.
- Commit: a valid buffer drives `ram_cs=ram_we=1`, `ram_be`=mask, in any cycle with no accepted read address phase; reads take priority and the write stays pending.
- Buffer is free before every new write data phase: the new write's address phase never uses the port, so the old entry commits then.
- Reads: `ram_cs=1, ram_we=0` combinationally in the accepted address phase. In the first data-phase cycle `ram_rdata` is merged with the buffer (buffered lanes replace SRAM lanes when buffer valid and word addresses match), captured, and held on `HRDATA` until the next read completes.
- FSM: IDLE → RD_WAIT (read accepted, `WAIT_STATES`>0) → IDLE after `WAIT_STATES` cycles with `HREADYOUT=0`; IDLE → ERR1 (bad size) → ERR2 → IDLE.
- ERR1: `HREADYOUT=0, HRESP=1`; ERR2: `HREADYOUT=1, HRESP=1`. Transfers presented during ERR2 are accepted normally.
- New transfers are not accepted while `HREADYOUT=0` (master holds `HREADY` low).

## Timing
- Reset values: `HRDATA=0`, `HREADYOUT=1`, `HRESP=0`, `ram_cs=0`, `ram_we=0`, `ram_be=0`, buffer invalid, FSM IDLE.
- Reset mid-transfer discards a pending write; no SRAM write after `HRESET` rises.
- Write: data phase 1 cycle, zero wait; SRAM write 1+ cycles after the data phase.
- Read: data phase `1+WAIT_STATES` cycles; `HRDATA` valid on the edge `HREADYOUT` is high.
- Read address phase coinciding with a write data phase to the same word returns the new write data via forwarding.
- Sustained reads defer a buffered write indefinitely; forwarding keeps results coherent.
- Word address wraps modulo `2^(AW-LB)`.

## Test plan
- DW=32, WS=0: write 0x010=CAFEBABE, 0x014=12345678, read both back → exact values, zero waits.
- Byte writes 55/AA/BB/CC to 0x010..0x013, read word → CCBBAA55; byte reads → 55, AA, BB, CC.
- Write 0x014=DEADBEEF immediately followed by read 0x014 → DEADBEEF via forwarding; read 0x010 then write 0x014 pipelined → CCBBAA55, and 0x014 later reads DEADBEEF.
- WS=2: read 0x010 → `HREADYOUT` low exactly 2 cycles, then CCBBAA55.
- DW=32, HSIZE=3 write → ERR1/ERR2 two-cycle ERROR, no `ram_cs`, memory unchanged.
- DW=64: halfword write 0x00A=BEEF, then doubleword read 0x008 → BEEF in bits [31:16]; `HRESET` asserted with write pending → write lost, outputs at reset values.
